aes_inv_cipher_512: RTL and testbench

- Streaming AES-128 decryptor for 512-bit words, counterpart of the 512-bit encrypt datapath.
- Four independent 128-bit lanes share one set of round keys; fully pipelined, one 512-bit word per clock, no backpressure.
- Contains its own key-expansion FSM, because the inverse cipher consumes round keys last-first. Keys are expanded once per key load and held in registers.
- Sits on the receive/read path and recovers plaintext from the ciphertext stream produced by the encrypt side.

---
 rtl/aes_inv_cipher_512.sv | 232 +++++++++++++++++++++++
 tb/tb_aes_inv_cipher_512.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_512.sv
// rtl/aes_inv_cipher_512.sv - streaming multi-lane AES-128 decryptor with on-chip key expansion
module aes_inv_cipher_512 #(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [127:0]         key,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic                 data_in_valid,
  input  logic [LANES*128-1:0] data_in,
  input  logic                 data_in_last,
  output logic                 data_in_drop,
  output logic [LANES*128-1:0] data_out,
  output logic                 data_out_valid,
  output logic                 data_out_last
);
  // input register + initial AddRoundKey + ten inverse rounds
  localparam int LATENCY = 12;
  localparam int W       = LANES * 128;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // multiplicative inverse as a^254; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p, e;
    r = 8'h01;
    p = a;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aes_inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {aes_sbox(prev[23:16]), aes_sbox(prev[15:8]), aes_sbox(prev[7:0]), aes_sbox(prev[31:24])}
         ^ {rc, 24'h000000};
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // byte j of a lane sits at bits [127-8j -: 8]; row = j%4, column = j/4
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] st);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*((c+r)%4)+r) -: 8] = st[127-8*(4*c+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] st);
    logic [127:0] o;
    o = '0;
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = aes_inv_sbox(st[127-8*j -: 8]);
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_round_lane(input logic [127:0] st, input logic [127:0] rk,
                                                  input logic mix);
    logic [127:0] t, o;
    t = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
    o = t;
    if (mix)
      for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [W-1:0] inv_round(input logic [W-1:0] x, input logic [127:0] rk,
                                             input logic mix);
    logic [W-1:0] o;
    o = '0;
    for (int i = 0; i < LANES; i++) o[i*128 +: 128] = inv_round_lane(x[i*128 +: 128], rk, mix);
    return o;
  endfunction

  state_e             state_q, state_d;
  logic               load_key;
  logic [3:0]         r_q;
  logic [127:0]       rk_q [0:10];
  logic               key_ready_q;
  logic               drop_q;
  logic [3:0]         inflight_q;
  logic [W-1:0]       s_q [0:LATENCY-1];
  logic [LATENCY-1:0] v_q;
  logic [LATENCY-1:0] l_q;
  logic               accept;

  assign accept = data_in_valid & key_ready_q;

  // key-schedule FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state; a rekey also waits for a word accepted this very cycle, so that
  // word is never processed with a half-rewritten schedule
  always_comb begin
    state_d  = state_q;
    load_key = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          load_key = 1'b1;
          state_d  = EXPAND;
        end
      end
      EXPAND: begin
        if (r_q == 4'd10) state_d = READY;
      end
      READY: begin
        if (key_valid && (inflight_q == 4'd0) && !accept) begin
          load_key = 1'b1;
          state_d  = EXPAND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // round-key registers: rk0 on load, then one forward expansion step per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= 10; i++) rk_q[i] <= '0;
      r_q <= '0;
    end else if (load_key) begin
      rk_q[0] <= key;
      r_q     <= 4'd1;
    end else if (state_q == EXPAND) begin
      rk_q[r_q] <= next_rk(rk_q[r_q - 4'd1], rcon(r_q));
      r_q       <= r_q + 4'd1;
    end
  end

  // key_ready lags READY by a cycle and falls together with a rekey; drop flag; occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_ready_q <= 1'b0;
      drop_q      <= 1'b0;
      inflight_q  <= '0;
    end else begin
      key_ready_q <= (state_q == READY) && (state_d == READY);
      drop_q      <= data_in_valid & ~key_ready_q;
      case ({accept, v_q[LATENCY-1]})
        2'b10:   inflight_q <= inflight_q + 4'd1;
        2'b01:   inflight_q <= inflight_q - 4'd1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // datapath: input register, rk10 whitening, then rounds using rk9 down to rk0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) s_q[k] <= '0;
      v_q <= '0;
      l_q <= '0;
    end else begin
      s_q[0] <= data_in;
      s_q[1] <= s_q[0] ^ {LANES{rk_q[10]}};
      for (int k = 1; k <= 10; k++) s_q[k+1] <= inv_round(s_q[k], rk_q[10-k], k != 10);
      v_q <= {v_q[LATENCY-2:0], accept};
      l_q <= {l_q[LATENCY-2:0], accept & data_in_last};
    end
  end

  assign key_ready      = key_ready_q;
  assign data_in_drop   = drop_q;
  assign data_out       = s_q[LATENCY-1];
  assign data_out_valid = v_q[LATENCY-1];
  assign data_out_last  = l_q[LATENCY-1];

endmodule

// File: tb/tb_aes_inv_cipher_512.sv
// tb/tb_aes_inv_cipher_512.sv - randomized self-checking bench for aes_inv_cipher_512
module tb_aes_inv_cipher_512;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic         data_in_valid = 1'b0;
  logic [511:0] data_in = '0;
  logic         data_in_last = 1'b0;
  logic         data_in_drop;
  logic [511:0] data_out;
  logic         data_out_valid;
  logic         data_out_last;

  aes_inv_cipher_512 #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .key(key), .key_valid(key_valid), .key_ready(key_ready),
    .data_in_valid(data_in_valid), .data_in(data_in), .data_in_last(data_in_last),
    .data_in_drop(data_in_drop), .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_last(data_out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference AES-128 encryptor on byte arrays
  logic [7:0]  sb [256];
  logic [7:0]  rcon_t [11];
  logic [31:0] mw [44];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic init_tables();
    logic [7:0] p, q, rc;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    rc = 8'h01;
    rcon_t[0] = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      rcon_t[i] = rc;
      rc = xt(rc);
    end
  endtask

  task automatic expand_model(input logic [127:0] k);
    logic [31:0] t;
    for (int i = 0; i < 4; i++) mw[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = mw[i-1];
      if (i % 4 == 0)
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rcon_t[i/4], 24'h0};
      mw[i] = mw[i-4] ^ t;
    end
  endtask

  function automatic logic [127:0] enc128(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   n [16];
    logic [31:0]  wd;
    logic [127:0] o;
    for (int j = 0; j < 16; j++) begin
      wd = mw[j/4];
      s[j] = pt[127-8*j -: 8] ^ wd[31-8*(j%4) -: 8];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int j = 0; j < 16; j++) s[j] = sb[s[j]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) n[r+4*c] = s[r+4*((c+r)%4)];
      s = n;
      if (rnd < 10)
        for (int c = 0; c < 4; c++) begin
          n[4*c]   = xt(s[4*c]) ^ xt(s[4*c+1]) ^ s[4*c+1] ^ s[4*c+2] ^ s[4*c+3];
          n[4*c+1] = s[4*c] ^ xt(s[4*c+1]) ^ xt(s[4*c+2]) ^ s[4*c+2] ^ s[4*c+3];
          n[4*c+2] = s[4*c] ^ s[4*c+1] ^ xt(s[4*c+2]) ^ xt(s[4*c+3]) ^ s[4*c+3];
          n[4*c+3] = xt(s[4*c]) ^ s[4*c] ^ s[4*c+1] ^ s[4*c+2] ^ xt(s[4*c+3]);
        end
      s = n;
      for (int j = 0; j < 16; j++) begin
        wd = mw[4*rnd + j/4];
        s[j] = s[j] ^ wd[31-8*(j%4) -: 8];
      end
    end
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
    return o;
  endfunction

  // scoreboard of expected outputs and expected drop pulses, keyed by cycle
  typedef struct {
    int           due;
    logic [511:0] data;
    logic         last;
  } exp_t;
  exp_t sbq[$];
  int   drop_due[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      logic dexp;
      dexp = (drop_due.size() > 0) && (drop_due[0] == cyc);
      if (dexp) void'(drop_due.pop_front());
      if (dexp || data_in_drop) check_eq("drop", data_in_drop, dexp);
      if (data_out_valid) begin
        if (sbq.size() == 0) check_eq("spurious_valid", data_out_valid, 0);
        else begin
          mon_e = sbq.pop_front();
          check_eq("out_cycle", cyc, mon_e.due);
          check_eq("out_data", data_out, mon_e.data);
          check_eq("out_last", data_out_last, mon_e.last);
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        check_eq("missing_out", data_out_valid, 1);
        void'(sbq.pop_front());
      end
    end
  end

  int           kv_cyc;
  logic [127:0] pend_key;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode: 1 = expected through, 0 = expected dropped, 2 = lost to reset
  task automatic send_raw(input logic [511:0] ct, input logic [511:0] pt, input logic last,
                          input int mode);
    exp_t e;
    data_in       = ct;
    data_in_valid = 1'b1;
    data_in_last  = last;
    if (mode == 1) begin
      e.due  = cyc + 12;
      e.data = pt;
      e.last = last;
      sbq.push_back(e);
    end else if (mode == 0) drop_due.push_back(cyc + 1);
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    data_in_last  = 1'b0;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic send(input logic [511:0] pt, input logic last, input int mode);
    logic [511:0] ct;
    for (int l = 0; l < 4; l++) ct[l*128 +: 128] = enc128(pt[l*128 +: 128]);
    send_raw(ct, pt, last, mode);
  endtask

  task automatic key_pulse(input logic [127:0] k);
    key       = k;
    key_valid = 1'b1;
    kv_cyc    = cyc;
    pend_key  = k;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_ready();
    do @(negedge clk); while (cyc < kv_cyc + 11);
    check_eq("kr_low", key_ready, 0);
    @(negedge clk);
    check_eq("kr_high", key_ready, 1);
    expand_model(pend_key);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || drop_due.size() != 0) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain", sbq.size() + drop_due.size(), 0);
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] kb, kc, kd;
    init_tables();
    kb = {$urandom, $urandom, $urandom, $urandom};
    kc = {$urandom, $urandom, $urandom, $urandom};
    kd = {$urandom, $urandom, $urandom, $urandom};

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", data_out_valid, 0);
    check_eq("rst_last", data_out_last, 0);
    check_eq("rst_data", data_out, 0);
    check_eq("rst_kr", key_ready, 0);
    check_eq("rst_drop", data_in_drop, 0);
    rst = 1'b0;
    idle(2);

    // known-answer vector on every lane
    key_pulse(FIPS_KEY);
    wait_ready();
    send_raw({4{FIPS_CT}}, {4{FIPS_PT}}, 1'b1, 1);
    drain();

    // 20 back-to-back words, last only on the 20th
    for (int i = 0; i < 20; i++) send(rand512(), i == 19, 1);
    drain();

    // words offered during expansion are dropped
    key_pulse(kc);
    for (int i = 0; i < 3; i++) send(rand512(), 1'b1, 0);
    wait_ready();
    send(rand512(), 1'b1, 1);
    send(rand512(), 1'b0, 1);
    drain();

    // rekey with words in flight is ignored, retry after drain succeeds
    for (int i = 0; i < 3; i++) send(rand512(), i == 2, 1);
    key_pulse(kb);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("kr_stay", key_ready, 1);
    end
    @(posedge clk);
    #1;
    drain();
    key_pulse(kb);
    wait_ready();
    for (int i = 0; i < 4; i++) send(rand512(), i[0], 1);
    drain();

    // reset mid-flight
    for (int i = 0; i < 5; i++) send(rand512(), 1'b1, 2);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", data_out_valid, 0);
    check_eq("mid_rst_data", data_out, 0);
    check_eq("mid_rst_kr", key_ready, 0);
    idle(2);
    rst = 1'b0;
    idle(20);
    check_eq("post_rst_kr", key_ready, 0);
    key_pulse(FIPS_KEY);
    wait_ready();
    send(rand512(), 1'b1, 1);
    drain();

    // long randomized loopback with gaps and random last
    key_pulse(kd);
    wait_ready();
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send(rand512(), $urandom_range(0, 1) == 1, 1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
